// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder: prefetches frame pixels from memory into a FWFT FIFO and presents one per read_en.
// Latency: rvalid into an empty FIFO shows on Data next cycle; read_en advances Data next cycle.
// Backpressure: fetch stalls while every FIFO slot is stored or reserved; VGA_FEEDER_PIPELINE_EN allows two outstanding reads.
module vga_pixel_feeder #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19,
    parameter int BASE_ADDR  = 0
) (
    input  logic              Clock25,
    input  logic              Reset,
    input  logic              read_en,
    input  logic              Vsync,
    output logic [23:0]       Data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [23:0]       mem_rdata,
    output logic              underrun
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int PW1   = PW + 1;
`ifdef VGA_FEEDER_PIPELINE_EN
    localparam int MAX_OUT = 2;
`else
    localparam int MAX_OUT = 1;
`endif
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [CW-1:0]     TOTAL_C = CW'(TOTAL);
    localparam logic [CW-1:0]     LAST_C  = CW'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;
    state_t state, state_nxt;

    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, occ;
    logic [PW1-1:0] reserved;
    logic [1:0]    outst, outst_nxt;
    logic [CW-1:0] fetched;
    logic          vsync_q, vsync_qq, restart;
    logic          fifo_empty, accept, rv, wr_en, pop, do_clear, can_issue;

    assign restart    = vsync_qq & ~vsync_q;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign occ        = wr_ptr - rd_ptr;
    // A slot counts as taken from the moment its read is granted, so writes never find the FIFO full.
    assign reserved   = {1'b0, occ} + PW1'(outst);

    assign mem_req   = (state == REQ) && !restart;
    assign accept    = mem_req && mem_gnt;
    assign rv        = mem_rvalid && (outst != 2'd0);
    assign wr_en     = rv && (state != FLUSH) && !restart;
    assign pop       = read_en && !fifo_empty && !restart;
    assign can_issue = (fetched < TOTAL_C) && (reserved < PW1'(FIFO_DEPTH)) && (outst < 2'(MAX_OUT));
    assign Data      = fifo_empty ? 24'd0 : fifo_mem[rd_ptr[AW-1:0]];

    always_comb begin
        state_nxt = state;
        outst_nxt = outst + 2'(accept) - 2'(rv);
        do_clear  = 1'b0;
        if (state == FLUSH) begin
            if (outst_nxt == 2'd0) begin
                state_nxt = IDLE;
                do_clear  = 1'b1;
            end
        end else if (restart) begin
            // Words still in flight must be drained before the frame can restart cleanly.
            do_clear  = 1'b1;
            state_nxt = (outst_nxt == 2'd0) ? IDLE : FLUSH;
        end else begin
            case (state)
                IDLE: if (can_issue) state_nxt = REQ;
                REQ:  if (accept) state_nxt = WAIT;
                WAIT: begin
                    if (can_issue)
                        state_nxt = REQ;
                    else if (outst_nxt == 2'd0)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock25) begin
        if (Reset) begin
            state    <= IDLE;
            outst    <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetched  <= '0;
            mem_addr <= BASE;
            underrun <= 1'b0;
            vsync_q  <= 1'b1;
            vsync_qq <= 1'b1;
        end else begin
            state    <= state_nxt;
            outst    <= outst_nxt;
            vsync_q  <= Vsync;
            vsync_qq <= vsync_q;
            if (do_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetched  <= '0;
                mem_addr <= BASE;
                underrun <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (read_en && fifo_empty)
                    underrun <= 1'b1;
                if (accept) begin
                    fetched <= fetched + CW'(1);
                    // Address parks on the last frame pixel instead of running past it.
                    if (fetched != LAST_C)
                        mem_addr <= mem_addr + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock25) begin
        if (wr_en)
            fifo_mem[wr_ptr[AW-1:0]] <= mem_rdata;
    end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder on a reduced 16x4 frame with a scripted/auto memory responder.
module tb_vga_pixel_feeder;
    localparam int H     = 16;
    localparam int V     = 4;
    localparam int TOTAL = H * V;
    localparam int DEPTH = 16;
    localparam int AW    = 19;

    logic          Clock25 = 1'b0;
    logic          Reset, read_en, Vsync;
    logic          mem_req, mem_gnt, mem_rvalid, underrun;
    logic [23:0]   Data, mem_rdata;
    logic [AW-1:0] mem_addr;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   mem_auto    = 1'b0;
    logic man_gnt     = 1'b0;
    logic man_rvalid  = 1'b0;
    logic [23:0] man_rdata = 24'd0;
    int   req_cnt;
    logic [AW-1:0] addr_log [TOTAL];

    vga_pixel_feeder #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FIFO_DEPTH(DEPTH),
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .Clock25   (Clock25),
        .Reset     (Reset),
        .read_en   (read_en),
        .Vsync     (Vsync),
        .Data      (Data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .underrun  (underrun)
    );

    initial forever #5 Clock25 = ~Clock25;

    // Memory side: scripted values when mem_auto is low, otherwise grant at once and return addr as data next cycle.
    initial begin
        logic          pend;
        logic [AW-1:0] pend_addr;
        pend       = 1'b0;
        pend_addr  = '0;
        req_cnt    = 0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 24'd0;
        forever begin
            @(negedge Clock25);
            if (!mem_auto) begin
                pend       = 1'b0;
                req_cnt    = 0;
                mem_gnt    = man_gnt;
                mem_rvalid = man_rvalid;
                mem_rdata  = man_rdata;
            end else begin
                mem_rvalid = pend;
                mem_rdata  = pend ? 24'(pend_addr) : 24'd0;
                pend       = 1'b0;
                mem_gnt    = mem_req;
                if (mem_req) begin
                    pend      = 1'b1;
                    pend_addr = mem_addr;
                    if (req_cnt < TOTAL)
                        addr_log[req_cnt] = mem_addr;
                    req_cnt++;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset   = 1'b1;
        read_en = 1'b0;
        Vsync   = 1'b1;
        tick(3);
        chk("rst_data", Data, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_underrun", underrun, 0);

        Reset = 1'b0;
        tick();
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);

        // Grant withheld for 5 cycles; a pop on the empty FIFO in the first one.
        read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            read_en = 1'b0;
            chk("hold_req", mem_req, 1);
            chk("hold_addr", mem_addr, 0);
        end
        chk("underrun_set", underrun, 1);
        chk("underrun_data", Data, 0);

        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        chk("gnt_addr_inc", mem_addr, 1);
        chk("wait_req_low", mem_req, 0);

        man_rvalid = 1'b1;
        man_rdata  = 24'h5A5A5A;
        tick();
        man_rvalid = 1'b0;
        chk("rvalid_data", Data, 24'h5A5A5A);
        chk("underrun_sticky", underrun, 1);
        tick();
        chk("second_req", mem_req, 1);
        chk("second_addr", mem_addr, 1);

        // Vsync falls while the second read is outstanding.
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        Vsync   = 1'b0;
        tick();
        Vsync = 1'b1;
        tick();
        chk("flush_data", Data, 0);
        chk("flush_req", mem_req, 0);
        chk("flush_underrun", underrun, 0);
        tick(2);
        chk("flush_wait_req", mem_req, 0);
        man_rvalid = 1'b1;
        man_rdata  = 24'hABCDEF;
        tick();
        man_rvalid = 1'b0;
        chk("late_word_dropped", Data, 0);
        chk("late_word_no_req", mem_req, 0);
        tick();
        chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, 0);

        // Fill with no pops: exactly DEPTH requests.
        mem_auto = 1'b1;
        tick(100);
        chk("fill_req_count", req_cnt, DEPTH);
        chk("fill_req_idle", mem_req, 0);
        chk("fill_head", Data, 0);
        for (int i = 0; i < DEPTH; i++)
            chk("fill_addr", addr_log[i], i);
        tick(20);
        chk("fill_stays_idle", req_cnt, DEPTH);

        // Drain the whole frame at one pop per 4 cycles.
        for (int i = 0; i < TOTAL; i++) begin
            chk("pop_data", Data, i);
            read_en = 1'b1;
            tick();
            read_en = 1'b0;
            tick(3);
        end
        tick(10);
        chk("frame_req_count", req_cnt, TOTAL);
        chk("frame_last_addr", mem_addr, TOTAL - 1);
        chk("frame_last_logged", addr_log[TOTAL-1], TOTAL - 1);
        chk("frame_req_idle", mem_req, 0);
        chk("frame_empty", Data, 0);
        chk("frame_no_underrun", underrun, 0);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk("post_frame_underrun", underrun, 1);
        tick(5);
        chk("post_frame_no_req", mem_req, 0);

        // Restart from IDLE after the frame completes.
        mem_auto = 1'b0;
        Vsync    = 1'b0;
        tick();
        Vsync = 1'b1;
        tick();
        chk("restart2_req_low", mem_req, 0);
        chk("restart2_underrun", underrun, 0);
        chk("restart2_data", Data, 0);
        tick();
        chk("restart2_req", mem_req, 1);
        chk("restart2_addr", mem_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
